ml_result_packer: RTL and testbench



---
 rtl/ml_model_pkg.sv | 40 ++++
 rtl/ml_result_packer_if.sv | 20 ++
 rtl/ml_result_fifo.sv | 67 ++++++
 rtl/ml_result_packer_chk.sv | 27 ++
 rtl/ml_result_packer.sv | 176 +++++++++++++++++
 tb/tb_ml_result_packer.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/ml_model_pkg.sv
// ---------------------------------------------------------------------------
// ml_model_pkg
// Constants shared by ml_model and its downstream result packer, the
// serialiser state type, and the helper that slices a 140-bit result into
// 32-bit stream words.
// ---------------------------------------------------------------------------
package ml_model_pkg;

    localparam int MODEL_IN_W       = 120;
    localparam int MODEL_OUT_W      = 140;
    localparam int MODEL_LATENCY    = 6;
    localparam int AXIS_W           = 32;
    localparam int WORDS_PER_RESULT = 5;
    localparam int WIDX_W           = 3;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

    // Word idx of a result. The last word carries the 12 leftover MSBs,
    // zero-extended to the bus width.
    function automatic logic [AXIS_W-1:0] result_word(
        input logic [MODEL_OUT_W-1:0] res,
        input logic [WIDX_W-1:0]      idx
    );
        logic [AXIS_W-1:0] word;
        word = 32'd0;
        case (idx)
            3'd0:    word = res[31:0];
            3'd1:    word = res[63:32];
            3'd2:    word = res[95:64];
            3'd3:    word = res[127:96];
            3'd4:    word = {20'd0, res[139:128]};
            default: word = 32'd0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ml_result_packer_if.sv
// ---------------------------------------------------------------------------
// ml_result_packer_if
// AXI-Stream link carrying serialised results.
//   tdata  : 32-bit result word
//   tvalid : word valid
//   tready : sink accepts
//   tlast  : final word of a result
// master = packer side, slave = downstream sink side.
// ---------------------------------------------------------------------------
interface ml_result_packer_if
    import ml_model_pkg::*;
();
    logic [AXIS_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/ml_result_fifo.sv
// ---------------------------------------------------------------------------
// ml_result_fifo
// Synchronous DEPTH x WIDTH FIFO holding captured model results.
//   clk, rst_n       : clock, async active-low reset (pointers only)
//   wr_en, wr_data   : push
//   rd_en            : pop of the current head
//   full, empty      : status
//   head             : oldest entry (valid while !empty)
//   count            : current occupancy
// DEPTH must be a power of two; pointers carry one extra wrap bit so that
// full and empty can be told apart when the addresses match.
// ---------------------------------------------------------------------------
module ml_result_fifo
    import ml_model_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = MODEL_OUT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic                   full,
    output logic                   empty,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count  = r_wr_ptr - r_rd_ptr;
    assign head   = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array: payload only, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ml_result_packer_chk.sv
// ---------------------------------------------------------------------------
// ml_result_packer_chk
// Property checker for ml_result_packer.
//   wr_en/full            : buffer write strobe and full flag
//   tvalid/tready/tdata/tlast : outgoing stream
// ---------------------------------------------------------------------------
module ml_result_packer_chk (
    input logic        clk,
    input logic        rst_n,
    input logic        wr_en,
    input logic        full,
    input logic        tvalid,
    input logic        tready,
    input logic [31:0] tdata,
    input logic        tlast
);
    // The credit loop must make a write into a full buffer impossible.
    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) wr_en |-> !full
    );

    // A stalled beat keeps its payload and stays valid until taken.
    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (tvalid && !tready) |=> (tvalid && $stable(tdata) && $stable(tlast))
    );
endmodule

// File: rtl/ml_result_packer.sv
// ---------------------------------------------------------------------------
// ml_result_packer
// Tracks real samples through the non-stallable ml_model pipeline, captures
// each 140-bit result as it exits, buffers it and streams it as a 5-beat
// 32-bit AXI-Stream packet. A credit is consumed per accepted sample and
// returned when its packet's last beat is taken, so the buffer can never
// overflow.
//   clk, rst_n : clock, async active-low reset
//   in_valid   : sample entering ml_model on this edge is real
//   in_ready   : a credit is available
//   model_out  : ml_model result bus
//   m_axis     : outgoing result stream (master)
//   overflow   : sticky, in_valid seen without a credit
// ---------------------------------------------------------------------------
module ml_result_packer
    import ml_model_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = MODEL_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MODEL_OUT_W-1:0] model_out,
    ml_result_packer_if.master     m_axis,
    output logic                   overflow
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int FCW = $clog2(DEPTH) + 1;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS_PER_RESULT - 1);

    logic [CW-1:0]          r_credits;
    logic [LATENCY-1:0]     r_vld;
    logic                   r_overflow;
    ser_state_e             r_state;
    logic [WIDX_W-1:0]      r_widx;
    logic                   r_tvalid;
    logic                   r_tlast;

    logic                   w_accept;
    logic                   w_wr_en;
    logic                   w_hs;
    logic                   w_pop;
    logic                   w_more;
    logic                   w_full;
    logic                   w_empty;
    logic [MODEL_OUT_W-1:0] w_head;
    logic [FCW-1:0]         w_count;

    assign in_ready = (r_credits != {CW{1'b0}});
    assign w_accept = in_valid && in_ready;
    assign w_wr_en  = r_vld[LATENCY-1];
    assign w_hs     = r_tvalid && m_axis.tready;
    assign w_pop    = w_hs && r_tlast;
    // After popping, another packet is ready if one is left behind or the
    // pipeline delivers one on this same edge.
    assign w_more   = w_wr_en || (w_count > FCW'(1));

    assign overflow      = r_overflow;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    // Head only changes on a pop, so the word is stable during stalls.
    assign m_axis.tdata  = (r_state == SER_SEND) ? result_word(w_head, r_widx)
                                                 : 32'd0;

    ml_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MODEL_OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_data (model_out),
        .rd_en   (w_pop),
        .full    (w_full),
        .empty   (w_empty),
        .head    (w_head),
        .count   (w_count)
    );

    ml_result_packer_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (w_wr_en),
        .full   (w_full),
        .tvalid (r_tvalid),
        .tready (m_axis.tready),
        .tdata  (m_axis.tdata),
        .tlast  (r_tlast)
    );

    // Credit counter: an accept takes one, a final-beat pop returns one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CW'(DEPTH);
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Valid tokens shadowing samples through the model pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= {LATENCY{1'b0}};
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], w_accept};
        end
    end

    // Sticky flag for samples offered without a credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    // Serialiser FSM with registered tvalid/tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SER_IDLE;
            r_widx   <= 3'd0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            case (r_state)
                SER_IDLE: begin
                    if (!w_empty) begin
                        r_state  <= SER_SEND;
                        r_widx   <= 3'd0;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                    end else begin
                        r_state  <= SER_IDLE;
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                    end
                end
                SER_SEND: begin
                    if (w_hs && (r_widx == LAST_IDX)) begin
                        r_widx  <= 3'd0;
                        r_tlast <= 1'b0;
                        if (w_more) begin
                            r_state  <= SER_SEND;
                            r_tvalid <= 1'b1;
                        end else begin
                            r_state  <= SER_IDLE;
                            r_tvalid <= 1'b0;
                        end
                    end else if (w_hs) begin
                        r_widx  <= r_widx + 3'd1;
                        r_tlast <= (r_widx == (LAST_IDX - 3'd1));
                    end else begin
                        r_widx  <= r_widx;
                        r_tlast <= r_tlast;
                    end
                end
                default: begin
                    r_state  <= SER_IDLE;
                    r_widx   <= 3'd0;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ml_result_packer.sv
// ---------------------------------------------------------------------------
// tb_ml_result_packer
// Drives ml_result_packer as ml_model would (results appear on model_out
// LATENCY edges after the accepting edge) and compares the stream against a
// queue of expected results, a credit count and a sticky overflow flag.
// ---------------------------------------------------------------------------
module tb_ml_result_packer;
    import ml_model_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [139:0] model_out;
    logic         overflow;

    ml_result_packer_if axis_if ();

    ml_result_packer #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .model_out (model_out),
        .m_axis    (axis_if.master),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fails  = 0;
    logic [139:0] slot [16];
    logic [139:0] exp_q [$];
    int           beat;
    int           outstanding;
    logic         exp_ovf;
    int           cyc;
    int           n_acc;
    int           last_acc_cyc;
    int           first_valid_cyc;
    int           tv_cnt;
    int           pop_cnt;
    bit           stall_seen;
    logic [31:0]  stall_data;
    logic         stall_last;
    bit           use_fixed;
    logic [139:0] fixed_val;

    task automatic check_eq(input string tag, input logic [139:0] obs, input logic [139:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [139:0] rnd_res();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[139:0];
    endfunction

    // Reference slicing: word w of a result, last word holds bits 139:128.
    function automatic logic [31:0] beat_of(input logic [139:0] r, input int w);
        if (w == 4) return {20'd0, r[139:128]};
        return r[32*w +: 32];
    endfunction

    task automatic clear_model();
        exp_q.delete();
        beat        = 0;
        outstanding = 0;
        exp_ovf     = 1'b0;
        stall_seen  = 1'b0;
    endtask

    // One clock: observe at the falling edge, then drive for the next rise.
    task automatic cycle(input logic iv, input logic tr, input bit gate);
        logic [139:0] v;
        bit hs_tv;
        @(negedge clk);
        check_eq("in_ready", in_ready, outstanding < DEPTH);
        check_eq("overflow", overflow, exp_ovf);
        if (stall_seen) begin
            check_eq("stall_tvalid", axis_if.tvalid, 1'b1);
            check_eq("stall_tdata", axis_if.tdata, stall_data);
            check_eq("stall_tlast", axis_if.tlast, stall_last);
        end
        in_valid       = gate ? (iv & in_ready) : iv;
        axis_if.tready = tr;
        model_out      = slot[cyc % 16];
        slot[cyc % 16] = rnd_res();
        #1;
        hs_tv = axis_if.tvalid;
        if (hs_tv) begin
            tv_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("stale_tvalid", axis_if.tvalid, 1'b0);
            end else if (tr) begin
                check_eq("tdata", axis_if.tdata, beat_of(exp_q[0], beat));
                check_eq("tlast", axis_if.tlast, beat == 4);
                beat++;
                if (beat == 5) begin
                    void'(exp_q.pop_front());
                    beat = 0;
                    outstanding--;
                    pop_cnt++;
                end
            end
        end
        if (in_valid && !in_ready) exp_ovf = 1'b1;
        if (in_valid && in_ready) begin
            v = use_fixed ? fixed_val : rnd_res();
            use_fixed = 1'b0;
            slot[(cyc + LAT) % 16] = v;
            exp_q.push_back(v);
            outstanding++;
            n_acc++;
            last_acc_cyc = cyc;
        end
        stall_seen = axis_if.tvalid && !tr;
        stall_data = axis_if.tdata;
        stall_last = axis_if.tlast;
        cyc++;
    endtask

    task automatic drain(input int budget, input bit rnd_ready);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle(1'b0, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tvalid"}, axis_if.tvalid, 1'b0);
        check_eq({tag, "_tlast"}, axis_if.tlast, 1'b0);
        check_eq({tag, "_tdata"}, axis_if.tdata, 32'd0);
        check_eq({tag, "_in_ready"}, in_ready, 1'b1);
        check_eq({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        int guard;
        int tv0;
        int pop0;
        for (int i = 0; i < 16; i++) slot[i] = rnd_res();
        clear_model();
        cyc = 0; n_acc = 0; tv_cnt = 0; pop_cnt = 0;
        first_valid_cyc = -1; use_fixed = 1'b0; last_acc_cyc = 0;
        rst_n = 1'b0; in_valid = 1'b0; axis_if.tready = 1'b0; model_out = 140'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single known result, tready high: beat values and first-beat latency.
        fixed_val = {12'hABB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
        use_fixed = 1'b1;
        first_valid_cyc = -1;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b1, 1'b0);
        check_eq("first_beat_latency", 32'(first_valid_cyc - last_acc_cyc), 32'd8);
        check_eq("single_done", exp_q.size(), 0);

        // Credit exhaustion: 8 accepts, then a 9th offer sets overflow.
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        check_eq("exhaust_held", exp_q.size(), 8);
        drain(200, 1'b0);

        // Credit low-water: accepts coinciding with final-beat returns.
        repeat (7) cycle(1'b1, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        repeat (60) cycle(1'b1, 1'b1, 1'b1);
        drain(200, 1'b0);

        // Backpressure: 40 accepted samples under random tready.
        n_acc = 0;
        guard = 0;
        while (n_acc < 40 && guard < 3000) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            guard++;
        end
        check_eq("bp_accepts", n_acc, 40);
        drain(2000, 1'b1);

        // Reset in the middle of a packet with three results buffered.
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        guard = 0;
        while (beat < 2 && guard < 20) begin
            cycle(1'b0, 1'b1, 1'b0);
            guard++;
        end
        check_eq("mid_packet_reached", beat, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) cycle(1'b0, 1'b1, 1'b0);

        // Throughput: upstream follows in_ready, tready held high.
        repeat (30) cycle(1'b1, 1'b1, 1'b1);
        tv0  = tv_cnt;
        pop0 = pop_cnt;
        repeat (60) cycle(1'b1, 1'b1, 1'b1);
        check_eq("tput_tvalid_cycles", tv_cnt - tv0, 60);
        check_eq("tput_results", pop_cnt - pop0, 12);
        drain(200, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
